// File: rtl/dtlb_fill_ctrl_if.sv
// Bus bundle for the DTLB fill controller: miss intake, page-walk handshake,
// TLB write port and fault report.
interface dtlb_fill_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int VPN_W  = 50
);
  logic              miss_en;
  logic [VPN_W-1:0]  miss_vpn;
  logic [7:0]        miss_lru;
  logic              busy;
  logic              flush;

  logic              walk_req_en;
  logic [VPN_W-1:0]  walk_req_vpn;
  logic              walk_req_rdy;
  logic              walk_rsp_en;
  logic              walk_rsp_fault;
  logic [DATA_W-1:0] walk_rsp_data0;
  logic [DATA_W-1:0] walk_rsp_data1;

  logic              tlb_write_wen;
  logic [1:0]        tlb_write_way;
  logic [VPN_W-1:0]  tlb_write_vpn;
  logic [DATA_W-1:0] tlb_write_data0;
  logic [DATA_W-1:0] tlb_write_data1;

  logic              fault_en;
  logic [VPN_W-1:0]  fault_vpn;

  modport master (
    input  miss_en, miss_vpn, miss_lru, flush,
    input  walk_req_rdy, walk_rsp_en, walk_rsp_fault, walk_rsp_data0, walk_rsp_data1,
    output busy, walk_req_en, walk_req_vpn,
    output tlb_write_wen, tlb_write_way, tlb_write_vpn, tlb_write_data0, tlb_write_data1,
    output fault_en, fault_vpn
  );

  modport slave (
    output miss_en, miss_vpn, miss_lru, flush,
    output walk_req_rdy, walk_rsp_en, walk_rsp_fault, walk_rsp_data0, walk_rsp_data1,
    input  busy, walk_req_en, walk_req_vpn,
    input  tlb_write_wen, tlb_write_way, tlb_write_vpn, tlb_write_data0, tlb_write_data1,
    input  fault_en, fault_vpn
  );
endinterface

// File: rtl/dtlb_fill_ctrl.sv
// DTLB miss/fill controller: 2-entry deduplicating miss queue, one outstanding
// page walk, victim-way TLB write or fault report per walk.
module dtlb_fill_ctrl #(
  parameter int DATA_W = 64,
  parameter int VPN_W  = 50
) (
  input  logic           clk,
  input  logic           rst,
  dtlb_fill_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [VPN_W-1:0]  q_vpn [2];
  logic [1:0]        q_way [2];
  logic [1:0]        q_vld;
  logic [1:0]        count;
  logic              wr_ptr, rd_ptr;
  logic              push, pop, dup;
  logic [VPN_W-1:0]  head_vpn;
  logic [1:0]        head_way;

  logic              rsp_fault_p1;
  logic [DATA_W-1:0] rsp_data0_p1, rsp_data1_p1;

  // Lowest-numbered way whose LRU field is zero, way 0 if none.
  function automatic logic [1:0] pick_victim(input logic [7:0] lru);
    logic [1:0] way;
    way = 2'd0;
    if (lru[7:6] == 2'b00) way = 2'd3;
    if (lru[5:4] == 2'b00) way = 2'd2;
    if (lru[3:2] == 2'b00) way = 2'd1;
    if (lru[1:0] == 2'b00) way = 2'd0;
    return way;
  endfunction

  always_comb begin
    q_vld[0] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'b0));
    q_vld[1] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'b1));
  end

  assign dup      = (q_vld[0] && (q_vpn[0] == bus.miss_vpn)) ||
                    (q_vld[1] && (q_vpn[1] == bus.miss_vpn));
  assign push     = bus.miss_en && (count != 2'd2) && !bus.flush && !dup;
  assign pop      = (state == WRITE);
  assign head_vpn = q_vpn[rd_ptr];
  assign head_way = q_way[rd_ptr];
  assign bus.busy = (count == 2'd2);

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Queue payload is data: written on enqueue, qualified by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_vpn[wr_ptr] <= bus.miss_vpn;
      q_way[wr_ptr] <= pick_victim(bus.miss_lru);
    end
  end

  // Stage p1: walk response held for the WRITE cycle.
  always_ff @(posedge clk) begin
    if ((state == WAIT) && bus.walk_rsp_en) begin
      rsp_fault_p1 <= bus.walk_rsp_fault;
      rsp_data0_p1 <= bus.walk_rsp_data0;
      rsp_data1_p1 <= bus.walk_rsp_data1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt           = state;
    bus.walk_req_en     = 1'b0;
    bus.walk_req_vpn    = '0;
    bus.tlb_write_wen   = 1'b0;
    bus.tlb_write_way   = 2'd0;
    bus.tlb_write_vpn   = '0;
    bus.tlb_write_data0 = '0;
    bus.tlb_write_data1 = '0;
    bus.fault_en        = 1'b0;
    bus.fault_vpn       = '0;
    case (state)
      IDLE: begin
        if (!bus.flush && (count != 2'd0)) state_nxt = REQ;
      end
      REQ: begin
        if (bus.flush) begin
          state_nxt = IDLE;
        end else begin
          bus.walk_req_en  = 1'b1;
          bus.walk_req_vpn = head_vpn;
          if (bus.walk_req_rdy) state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.flush)            state_nxt = DRAIN;
        else if (bus.walk_rsp_en) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = IDLE;
        if (!bus.flush) begin
          if (rsp_fault_p1) begin
            bus.fault_en  = 1'b1;
            bus.fault_vpn = head_vpn;
          end else begin
            bus.tlb_write_wen   = 1'b1;
            bus.tlb_write_way   = head_way;
            bus.tlb_write_vpn   = head_vpn;
            bus.tlb_write_data0 = rsp_data0_p1;
            bus.tlb_write_data1 = rsp_data1_p1;
          end
        end
      end
      DRAIN: begin
        // The walker still owes one response for the flushed request.
        if (!bus.flush && bus.walk_rsp_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dtlb_fill_ctrl.sv
// Directed bench for dtlb_fill_ctrl with a queued scoreboard of expected walk
// requests and TLB writes/faults, checked by an independent monitor.
module tb_dtlb_fill_ctrl;
  localparam int DW = 64;
  localparam int VW = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dtlb_fill_ctrl_if #(.DATA_W(DW), .VPN_W(VW)) bus ();
  dtlb_fill_ctrl #(.DATA_W(DW), .VPN_W(VW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic          flt;
    logic [VW-1:0] vpn;
    logic [1:0]    way;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } exp_t;

  exp_t          exp_q[$];
  logic [VW-1:0] req_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  exp_t          mon_e;
  logic [VW-1:0] mon_v;
  always @(negedge clk) begin
    if (bus.walk_req_en && bus.walk_req_rdy) begin
      if (req_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL req_unexpected: got vpn 0x%0h expected no request", bus.walk_req_vpn);
      end else begin
        mon_v = req_q.pop_front();
        chk("req_vpn", 64'(bus.walk_req_vpn), 64'(mon_v));
      end
    end
    if (bus.tlb_write_wen || bus.fault_en) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL out_unexpected: got wen=%0b fault=%0b expected no output",
                 bus.tlb_write_wen, bus.fault_en);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_fault_en", 64'(bus.fault_en), 64'(mon_e.flt));
        chk("out_wen", 64'(bus.tlb_write_wen), 64'(!mon_e.flt));
        if (mon_e.flt) begin
          chk("fault_vpn", 64'(bus.fault_vpn), 64'(mon_e.vpn));
        end else begin
          chk("write_vpn", 64'(bus.tlb_write_vpn), 64'(mon_e.vpn));
          chk("write_way", 64'(bus.tlb_write_way), 64'(mon_e.way));
          chk("write_data0", bus.tlb_write_data0, mon_e.d0);
          chk("write_data1", bus.tlb_write_data1, mon_e.d1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic exp_wr(input logic [VW-1:0] v, input logic [1:0] w,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    exp_t e;
    e.flt = 1'b0; e.vpn = v; e.way = w; e.d0 = d0; e.d1 = d1;
    exp_q.push_back(e);
  endtask

  task automatic exp_flt(input logic [VW-1:0] v);
    exp_t e;
    e.flt = 1'b1; e.vpn = v; e.way = 2'd0; e.d0 = '0; e.d1 = '0;
    exp_q.push_back(e);
  endtask

  task automatic miss(input logic [VW-1:0] v, input logic [7:0] lru);
    bus.miss_en = 1'b1; bus.miss_vpn = v; bus.miss_lru = lru;
    step();
    bus.miss_en = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.walk_req_en && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 64'(bus.walk_req_en), 64'd1);
  endtask

  // Accept the pending request, answer after gap WAIT cycles, check pulse timing.
  task automatic walk(input logic flt, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input int gap);
    wait_req();
    step(); bus.walk_req_rdy = 1'b1;
    step(); bus.walk_req_rdy = 1'b0;
    @(negedge clk);
    chk("req_dropped_in_wait", 64'(bus.walk_req_en), 64'd0);
    repeat (gap) step();
    bus.walk_rsp_en = 1'b1; bus.walk_rsp_fault = flt;
    bus.walk_rsp_data0 = d0; bus.walk_rsp_data1 = d1;
    step();
    bus.walk_rsp_en = 1'b0; bus.walk_rsp_fault = 1'b0;
    bus.walk_rsp_data0 = 64'hBAD0_BAD0_BAD0_BAD0; bus.walk_rsp_data1 = 64'hBAD1_BAD1_BAD1_BAD1;
    @(negedge clk);
    chk("pulse_at_m1", 64'(flt ? bus.fault_en : bus.tlb_write_wen), 64'd1);
    chk("other_pulse_low", 64'(flt ? bus.tlb_write_wen : bus.fault_en), 64'd0);
    step();
    @(negedge clk);
    chk("pulse_one_cycle", 64'(bus.tlb_write_wen | bus.fault_en), 64'd0);
    step();
  endtask

  task automatic quiet(input string name, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (bus.walk_req_en || bus.tlb_write_wen || bus.fault_en) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   64'(bus.busy), 64'd0);
    chk({tag, "_req_en"}, 64'(bus.walk_req_en), 64'd0);
    chk({tag, "_req_vpn"}, 64'(bus.walk_req_vpn), 64'd0);
    chk({tag, "_wen"},    64'(bus.tlb_write_wen), 64'd0);
    chk({tag, "_way"},    64'(bus.tlb_write_way), 64'd0);
    chk({tag, "_wvpn"},   64'(bus.tlb_write_vpn), 64'd0);
    chk({tag, "_d0"},     bus.tlb_write_data0, 64'd0);
    chk({tag, "_d1"},     bus.tlb_write_data1, 64'd0);
    chk({tag, "_fault"},  64'(bus.fault_en), 64'd0);
    chk({tag, "_fvpn"},   64'(bus.fault_vpn), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.miss_en = 1'b0; bus.miss_vpn = '0; bus.miss_lru = '0; bus.flush = 1'b0;
    bus.walk_req_rdy = 1'b0; bus.walk_rsp_en = 1'b0; bus.walk_rsp_fault = 1'b0;
    bus.walk_rsp_data0 = '0; bus.walk_rsp_data1 = '0;
    step(); step();
    @(negedge clk);
    chk_all_zero("reset");
    step();
    rst = 1'b0;
    step();

    // Single miss: victim way 1, request at N+2, held while not accepted.
    req_q.push_back(50'h12345);
    exp_wr(50'h12345, 2'd1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    bus.miss_en = 1'b1; bus.miss_vpn = 50'h12345; bus.miss_lru = 8'b11_10_00_01;
    step();
    bus.miss_en = 1'b0;
    @(negedge clk);
    chk("n1_req_en", 64'(bus.walk_req_en), 64'd0);
    step();
    @(negedge clk);
    chk("n2_req_en", 64'(bus.walk_req_en), 64'd1);
    chk("n2_req_vpn", 64'(bus.walk_req_vpn), 64'h12345);
    step();
    @(negedge clk);
    chk("n3_req_vpn_stable", 64'(bus.walk_req_vpn), 64'h12345);
    walk(1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1);

    // Two misses fill the queue; the third is dropped while busy.
    req_q.push_back(50'hA); req_q.push_back(50'hB);
    exp_wr(50'hA, 2'd0, 64'hAAAA_0000, 64'hAAAA_0001);
    exp_wr(50'hB, 2'd3, 64'hBBBB_0000, 64'hBBBB_0001);
    miss(50'hA, 8'b00_00_00_00);
    miss(50'hB, 8'b00_01_01_01);
    bus.miss_en = 1'b1; bus.miss_vpn = 50'hC; bus.miss_lru = 8'h00;
    @(negedge clk);
    chk("full_busy", 64'(bus.busy), 64'd1);
    step();
    bus.miss_en = 1'b0;
    walk(1'b0, 64'hAAAA_0000, 64'hAAAA_0001, 0);
    @(negedge clk);
    chk("after_pop_busy", 64'(bus.busy), 64'd0);
    walk(1'b0, 64'hBBBB_0000, 64'hBBBB_0001, 2);
    quiet("full_third_dropped", 6);

    // Duplicate miss while queued gives exactly one walk.
    req_q.push_back(50'hA);
    exp_wr(50'hA, 2'd0, 64'h1111, 64'h2222);
    miss(50'hA, 8'h00);
    miss(50'hA, 8'hFF);
    @(negedge clk);
    chk("dup_busy", 64'(bus.busy), 64'd0);
    walk(1'b0, 64'h1111, 64'h2222, 1);
    quiet("dup_single_req", 8);

    // Walk fault reports the VPN and writes nothing.
    req_q.push_back(50'h7);
    exp_flt(50'h7);
    miss(50'h7, 8'b01_01_01_01);
    walk(1'b1, 64'hDEAD, 64'hBEEF, 1);

    // Flush in WAIT with a second entry queued; late response discarded.
    req_q.push_back(50'h5);
    miss(50'h5, 8'h00);
    miss(50'h6, 8'h00);
    wait_req();
    step(); bus.walk_req_rdy = 1'b1;
    step(); bus.walk_req_rdy = 1'b0; bus.flush = 1'b1;
    step(); bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_req_en", 64'(bus.walk_req_en), 64'd0);
    step(); step();
    bus.walk_rsp_en = 1'b1; bus.walk_rsp_data0 = 64'h5555; bus.walk_rsp_data1 = 64'h5556;
    step();
    bus.walk_rsp_en = 1'b0;
    quiet("flush_no_output", 8);
    req_q.push_back(50'h9);
    exp_wr(50'h9, 2'd1, 64'h9990, 64'h9991);
    miss(50'h9, 8'b00_00_00_11);
    walk(1'b0, 64'h9990, 64'h9991, 0);

    // Reset during WAIT clears everything; the later response is ignored.
    req_q.push_back(50'h3);
    miss(50'h3, 8'h00);
    wait_req();
    step(); bus.walk_req_rdy = 1'b1;
    step(); bus.walk_req_rdy = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_wait");
    step();
    bus.walk_rsp_en = 1'b1; bus.walk_rsp_data0 = 64'h3333; bus.walk_rsp_data1 = 64'h3334;
    step();
    bus.walk_rsp_en = 1'b0;
    quiet("rst_rsp_ignored", 8);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("req_q_drained", 64'(req_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
